// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready load and bit-rate enable.
// Back-to-back words are accepted on the last-bit cycle, so frames follow each other with no gap.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_shift_en,
  output logic             o_serial,
  output logic             o_serial_valid,
  output logic             o_last,
  output logic             o_busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_next_sreg;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_next_cnt;
  logic             w_last;
  logic             w_ready;
  logic             w_xfer;
  logic [WIDTH-1:0] w_shifted;

  // Final bit of the frame is on the line.
  assign w_last = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH - 1));

  // Register advanced one bit toward the output end, vacated end zero-filled.
  assign w_shifted = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};

  // Accept in IDLE, or on the last bit once it is about to be consumed.
  always_comb begin
    w_ready = 1'b0;
    if (!rst_n) begin
      w_ready = 1'b0;
    end else if (r_state == S_IDLE) begin
      w_ready = 1'b1;
    end else if (w_last) begin
      w_ready = i_shift_en;
    end
  end

  assign w_xfer  = i_valid & w_ready;
  assign o_ready = w_ready;

  // Next-state, shift register and bit counter update.
  always_comb begin
    w_next_state = r_state;
    w_next_sreg  = r_sreg;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_next_sreg  = i_data;
          w_next_cnt   = '0;
          w_next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (i_shift_en) begin
          if (w_last) begin
            if (w_xfer) begin
              w_next_sreg = i_data;
              w_next_cnt  = '0;
            end else begin
              w_next_sreg  = '0;
              w_next_cnt   = '0;
              w_next_state = S_IDLE;
            end
          end else begin
            w_next_sreg = w_shifted;
            w_next_cnt  = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, shift register and counter; synchronous active-low reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_sreg  <= w_next_sreg;
      r_cnt   <= w_next_cnt;
    end
  end

  assign o_busy         = (r_state == S_SHIFT);
  assign o_serial_valid = (r_state == S_SHIFT);
  assign o_last         = w_last;
  assign o_serial       = (r_state == S_SHIFT) ?
                          (MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0]) : 1'b0;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: one MSB-first and one LSB-first serializer share all inputs.
module tb_piso_serializer;

  localparam int unsigned W = 8;

  typedef struct {
    logic b_msb;
    logic b_lsb;
    logic last;
  } exp_bit_t;

  logic         clk;
  logic         rst_n;
  logic         i_valid;
  logic [W-1:0] i_data;
  logic         i_shift_en;

  logic m_ready, m_serial, m_sval, m_last, m_busy;
  logic l_ready, l_serial, l_sval, l_last, l_busy;

  exp_bit_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  bit accepted;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(m_ready),
    .i_data(i_data), .i_shift_en(i_shift_en), .o_serial(m_serial),
    .o_serial_valid(m_sval), .o_last(m_last), .o_busy(m_busy)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(l_ready),
    .i_data(i_data), .i_shift_en(i_shift_en), .o_serial(l_serial),
    .o_serial_valid(l_sval), .o_last(l_last), .o_busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Output monitor: compare against the head of the expected-bit queue, consume on enabled edges.
  always @(negedge clk) begin
    logic     e_valid, e_ready;
    exp_bit_t h;
    e_valid = (q.size() != 0);
    h.b_msb = 1'b0;
    h.b_lsb = 1'b0;
    h.last  = 1'b0;
    if (e_valid) h = q[0];
    if (!rst_n)        e_ready = 1'b0;
    else if (!e_valid) e_ready = 1'b1;
    else               e_ready = h.last & i_shift_en;
    chk("msb_ready",  m_ready,  e_ready);
    chk("lsb_ready",  l_ready,  e_ready);
    chk("msb_sval",   m_sval,   e_valid);
    chk("lsb_sval",   l_sval,   e_valid);
    chk("msb_busy",   m_busy,   e_valid);
    chk("lsb_busy",   l_busy,   e_valid);
    chk("msb_serial", m_serial, h.b_msb);
    chk("lsb_serial", l_serial, h.b_lsb);
    chk("msb_last",   m_last,   h.last);
    chk("lsb_last",   l_last,   h.last);
    if (!rst_n) q.delete();
    else if (e_valid && i_shift_en) void'(q.pop_front());
  end

  // One clock: inputs already set; record a transfer, then return just after the edge.
  task automatic step();
    accepted = 1'b0;
    @(negedge clk);
    #1;
    if (rst_n && i_valid && m_ready) begin
      accepted = 1'b1;
      for (int k = 0; k < int'(W); k++) begin
        exp_bit_t e;
        e.b_msb = i_data[W-1-k];
        e.b_lsb = i_data[k];
        e.last  = (k == int'(W) - 1);
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Offer a word until accepted; shift enable pattern: period 1 = always, else one pulse per period.
  task automatic send(input logic [W-1:0] w, input int period, inout int ph);
    int tries;
    tries = 0;
    i_valid = 1'b1;
    i_data  = w;
    do begin
      i_shift_en = (ph % period) == 0;
      ph++;
      step();
      tries++;
    end while (!accepted && tries < 200);
    chk("send_accept_timeout", accepted, 1'b1);
    i_valid = 1'b0;
    i_data  = W'($urandom);
  endtask

  task automatic idle_cycles(input int n, input int period, inout int ph);
    for (int k = 0; k < n; k++) begin
      i_shift_en = (ph % period) == 0;
      ph++;
      i_data = W'($urandom);
      step();
    end
  endtask

  initial begin
    int ph;
    ph = 0;
    rst_n = 1'b0; i_valid = 1'b1; i_data = 8'hFF; i_shift_en = 1'b1;
    // Reset held with a pending word: nothing may load.
    for (int k = 0; k < 3; k++) step();
    rst_n = 1'b1; i_valid = 1'b0;
    idle_cycles(2, 1, ph);

    // Single MSB/LSB frame, then back-to-back frames with valid held.
    send(8'hA5, 1, ph);
    idle_cycles(10, 1, ph);
    send(8'h3C, 1, ph);
    send(8'hC3, 1, ph);
    idle_cycles(10, 1, ph);
    send(8'h01, 1, ph);
    idle_cycles(10, 1, ph);

    // Slow bit rate, with another word offered mid-frame.
    ph = 0;
    send(8'h81, 3, ph);
    idle_cycles(6, 3, ph);
    send(8'h5A, 3, ph);
    idle_cycles(30, 3, ph);

    // Reset in mid-frame, then a clean frame.
    send(8'hF0, 1, ph);
    idle_cycles(2, 1, ph);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle_cycles(1, 1, ph);
    send(8'hFF, 1, ph);
    idle_cycles(10, 1, ph);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      i_valid    = ($urandom_range(0, 1) == 1);
      i_data     = W'($urandom);
      i_shift_en = ($urandom_range(0, 3) != 0);
      rst_n      = ($urandom_range(0, 99) != 0);
      step();
    end

    // Drain with a bounded wait.
    rst_n = 1'b1; i_valid = 1'b0; i_shift_en = 1'b1;
    for (int k = 0; k < 40 && q.size() != 0; k++) step();
    chk("drain_timeout", q.size() == 0, 1'b1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
